// File: rtl/elevator_pkg.sv
// Shared types and helpers for the lift call scheduler and its LOOK target picker.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ARRIVE,
    HOME
  } state_e;

  localparam int unsigned MAX_FLOORS = 16;

  function automatic logic [MAX_FLOORS-1:0] onehot_floor(input logic [3:0] floor);
    onehot_floor        = '0;
    onehot_floor[floor] = 1'b1;
  endfunction

  // Positions reported beyond the top served floor are treated as the top floor.
  function automatic int unsigned sat_floor(input int unsigned floor, input int unsigned n_floors);
    return (floor >= n_floors) ? n_floors - 1 : floor;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Target offer / arrival link between the call scheduler (master) and the car controller (slave).
interface elevator_scheduler_if #(
  parameter int unsigned N_FLOORS = 4
);
  localparam int unsigned FW = $clog2(N_FLOORS);

  logic          tgt_valid;
  logic [FW-1:0] tgt_floor;
  logic          tgt_ready;
  logic          arrive;

  modport master (output tgt_valid, tgt_floor, input tgt_ready, arrive);
  modport slave  (input tgt_valid, tgt_floor, output tgt_ready, arrive);
endinterface

// File: rtl/elev_look_picker.sv
// Combinational LOOK target selection: current floor first, then nearest ahead, else nearest behind with a flip.
module elev_look_picker
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS = 4,
  localparam int unsigned FW = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FW-1:0]       cur_floor,
  input  logic                sweep_up,
  output logic                found,
  output logic [FW-1:0]       floor,
  output logic                flip
);

  logic [FW-1:0] cur_sat;
  logic [FW-1:0] above;
  logic [FW-1:0] below;
  logic          cur_hit;
  logic          has_above;
  logic          has_below;

  always_comb begin
    cur_sat   = FW'(sat_floor(32'(cur_floor), N_FLOORS));
    cur_hit   = 1'b0;
    has_above = 1'b0;
    has_below = 1'b0;
    above     = '0;
    below     = '0;
    // Ascending scan: first hit above is the nearest above, last hit below is the nearest below.
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (pending[i]) begin
        if (i == 32'(cur_sat)) begin
          cur_hit = 1'b1;
        end else if (i > 32'(cur_sat)) begin
          if (!has_above) begin
            has_above = 1'b1;
            above     = FW'(i);
          end
        end else begin
          has_below = 1'b1;
          below     = FW'(i);
        end
      end
    end

    found = |pending;
    floor = cur_sat;
    flip  = 1'b0;
    if (!cur_hit) begin
      if (sweep_up) begin
        if (has_above) begin
          floor = above;
        end else if (has_below) begin
          floor = below;
          flip  = 1'b1;
        end
      end else begin
        if (has_below) begin
          floor = below;
        end else if (has_above) begin
          floor = above;
          flip  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Lift call scheduler: latches calls, issues LOOK-ordered targets over a valid/ready link.
// Optional idle parking at HOME_FLOOR when built with ELEV_HOME_EN defined.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS   = 4,
  parameter int unsigned HOME_FLOOR = 0,
  parameter int unsigned HOME_DELAY = 64,
  localparam int unsigned FW = $clog2(N_FLOORS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_FLOORS-1:0]  call_req,
  input  logic [FW-1:0]        cur_floor,
  elevator_scheduler_if.master tgt,
  output logic [N_FLOORS-1:0]  pending,
  output logic                 sweep_up,
  output logic                 busy
);

  if (N_FLOORS < 2 || N_FLOORS > MAX_FLOORS || HOME_DELAY < 1 || HOME_FLOOR >= N_FLOORS) begin : g_cfg_check
    $error("elevator_scheduler: unsupported parameter set");
  end

  state_e              state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] clr;
  logic                tgt_valid_q, tgt_valid_d;
  logic [FW-1:0]       tgt_floor_q, tgt_floor_d;
  logic                sweep_up_q, sweep_up_d;

  logic                pick_found;
  logic [FW-1:0]       pick_floor;
  logic                pick_flip;

  elev_look_picker #(
    .N_FLOORS (N_FLOORS)
  ) u_picker (
    .pending   (pending_q),
    .cur_floor (cur_floor),
    .sweep_up  (sweep_up_q),
    .found     (pick_found),
    .floor     (pick_floor),
    .flip      (pick_flip)
  );

`ifdef ELEV_HOME_EN
  localparam int unsigned CW = $clog2(HOME_DELAY + 1);

  logic [CW-1:0] home_cnt_q, home_cnt_d;
  logic          home_trip_q, home_trip_d;
  logic          home_run;
  logic [FW-1:0] cur_sat;

  assign cur_sat    = FW'(sat_floor(32'(cur_floor), N_FLOORS));
  assign home_run   = (state_q == IDLE) && (pending_q == '0) && (call_req == '0)
                      && (cur_sat != FW'(HOME_FLOOR));
  assign home_cnt_d = home_run ? home_cnt_q + CW'(1) : '0;
  // Marks the outstanding trip as a parking move so its arrive clears no call.
  assign home_trip_d = (state_d == HOME) ? 1'b1
                     : (state_q == WAIT_ARRIVE && tgt.arrive) ? 1'b0
                     : home_trip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      home_cnt_q  <= '0;
      home_trip_q <= 1'b0;
    end else begin
      home_cnt_q  <= home_cnt_d;
      home_trip_q <= home_trip_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    tgt_valid_d = tgt_valid_q;
    tgt_floor_d = tgt_floor_q;
    sweep_up_d  = sweep_up_q;
    clr         = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = ISSUE;
          tgt_valid_d = 1'b1;
          tgt_floor_d = pick_floor;
          if (pick_flip) sweep_up_d = ~sweep_up_q;
        end
`ifdef ELEV_HOME_EN
        else if (home_run && home_cnt_q == CW'(HOME_DELAY - 1)) begin
          state_d     = HOME;
          tgt_valid_d = 1'b1;
          tgt_floor_d = FW'(HOME_FLOOR);
        end
`endif
      end
      ISSUE, HOME: begin
        if (tgt.tgt_ready) begin
          state_d     = WAIT_ARRIVE;
          tgt_valid_d = 1'b0;
        end
      end
      WAIT_ARRIVE: begin
        if (tgt.arrive) begin
          state_d = IDLE;
`ifdef ELEV_HOME_EN
          if (!home_trip_q)
`endif
          clr = N_FLOORS'(onehot_floor(4'(tgt_floor_q)));
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | call_req) & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      tgt_valid_q <= 1'b0;
      tgt_floor_q <= '0;
      sweep_up_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      tgt_valid_q <= tgt_valid_d;
      tgt_floor_q <= tgt_floor_d;
      sweep_up_q  <= sweep_up_d;
    end
  end

  assign tgt.tgt_valid = tgt_valid_q;
  assign tgt.tgt_floor = tgt_floor_q;
  assign pending       = pending_q;
  assign sweep_up      = sweep_up_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: directed scenarios plus randomized traffic against a LOOK reference model.
module tb_elevator_scheduler;
  localparam int unsigned N          = 6;
  localparam int unsigned HOME_FLOOR = 0;
  localparam int unsigned HOME_DELAY = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] call_req = '0;
  logic [2:0]   cur_floor = '0;
  logic [N-1:0] pending;
  logic         sweep_up;
  logic         busy;

  elevator_scheduler_if #(.N_FLOORS(N)) tgt_if();

  elevator_scheduler #(
    .N_FLOORS   (N),
    .HOME_FLOOR (HOME_FLOOR),
    .HOME_DELAY (HOME_DELAY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .call_req  (call_req),
    .cur_floor (cur_floor),
    .tgt       (tgt_if),
    .pending   (pending),
    .sweep_up  (sweep_up),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: pending set, phase 0=idle 1=offering 2=travelling, chosen target, direction.
  logic [N-1:0] m_pend;
  int           m_phase;
  int           m_tgt;
  logic         m_sweep;
  int           m_cur;
  logic         m_home;
  int           m_cnt;

  function automatic int m_sat(input int c);
    return (c >= int'(N)) ? int'(N) - 1 : c;
  endfunction

  function automatic int m_pick(input int c);
    int f;
    if (m_pend[c]) return c;
    for (int d = 1; d < int'(N); d++) begin
      f = m_sweep ? c + d : c - d;
      if (f >= 0 && f < int'(N) && m_pend[f]) return f;
    end
    for (int d = 1; d < int'(N); d++) begin
      f = m_sweep ? c - d : c + d;
      if (f >= 0 && f < int'(N) && m_pend[f]) begin
        m_sweep = ~m_sweep;
        return f;
      end
    end
    return c;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_phase = 0;
    m_tgt   = 0;
    m_sweep = 1'b1;
    m_home  = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic step(input logic [N-1:0] call, input logic ready, input logic arr);
    logic [N-1:0] clr;
    int c;
    call_req         = call;
    tgt_if.tgt_ready = ready;
    tgt_if.arrive    = arr;
    cur_floor        = 3'(m_cur);
    @(posedge clk);
    clr = '0;
    c   = m_sat(m_cur);
    case (m_phase)
      0: begin
        if (m_pend != '0) begin
          m_tgt   = m_pick(c);
          m_phase = 1;
          m_home  = 1'b0;
          m_cnt   = 0;
        end
`ifdef ELEV_HOME_EN
        else if (call == '0 && c != int'(HOME_FLOOR)) begin
          m_cnt++;
          if (m_cnt == int'(HOME_DELAY)) begin
            m_tgt   = int'(HOME_FLOOR);
            m_phase = 1;
            m_home  = 1'b1;
            m_cnt   = 0;
          end
        end else begin
          m_cnt = 0;
        end
`endif
      end
      1: if (ready) m_phase = 2;
      default: begin
        if (arr) begin
          if (!m_home) clr[m_tgt] = 1'b1;
          m_phase = 0;
        end
      end
    endcase
    m_pend = (m_pend | call) & ~clr;
    #1;
  endtask

  task automatic do_reset();
    call_req         = '0;
    tgt_if.tgt_ready = 1'b0;
    tgt_if.arrive    = 1'b0;
    rst_n            = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pending, tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up, busy} !== {6'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {pending, tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up, busy},
               {6'b0, 1'b0, 3'd0, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b1;
    m_cur = 3;
    step(6'b000010, 0, 0);
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL reset_pre_offer got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up}, {1'b1, 3'd1, 1'b0});
    end
    step(6'b000000, 1, 0);
    // Mid-cycle reset while travelling: outputs must clear without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pending, tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up, busy} !== {6'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", {pending, tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up, busy},
               {6'b0, 1'b0, 3'd0, 1'b1, 1'b0});
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_look_up();
    do_reset();
    m_cur = 0;
    step(6'b001010, 0, 0);
    checks++;
    if ({pending, tgt_if.tgt_valid} !== {6'b001010, 1'b0}) begin
      failures++;
      $display("FAIL up_latch got=%h exp=%h", {pending, tgt_if.tgt_valid}, {6'b001010, 1'b0});
    end
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {1'b1, 3'd1, 1'b1}) begin
      failures++;
      $display("FAIL up_first got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up}, {1'b1, 3'd1, 1'b1});
    end
    step(6'b000000, 1, 0);
    checks++;
    if ({tgt_if.tgt_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL up_accept got=%b exp=01", {tgt_if.tgt_valid, busy});
    end
    m_cur = 1;
    step(6'b000000, 0, 1);
    checks++;
    if ({pending, busy} !== {6'b001000, 1'b0}) begin
      failures++;
      $display("FAIL up_arrive1 got=%h exp=%h", {pending, busy}, {6'b001000, 1'b0});
    end
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {1'b1, 3'd3, 1'b1}) begin
      failures++;
      $display("FAIL up_second got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up}, {1'b1, 3'd3, 1'b1});
    end
    step(6'b000000, 1, 0);
    m_cur = 3;
    step(6'b000000, 0, 1);
    checks++;
    if ({pending, sweep_up, busy} !== {6'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL up_done got=%h exp=%h", {pending, sweep_up, busy}, {6'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_look_flip();
    do_reset();
    m_cur = 2;
    step(6'b000011, 0, 0);
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL flip_first got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up}, {1'b1, 3'd1, 1'b0});
    end
    step(6'b000000, 1, 0);
    m_cur = 1;
    step(6'b000000, 0, 1);
    checks++;
    if (pending !== 6'b000001) begin
      failures++;
      $display("FAIL flip_arrive got=%b exp=000001", pending);
    end
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL flip_second got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up}, {1'b1, 3'd0, 1'b0});
    end
    step(6'b000000, 1, 0);
    m_cur = 0;
    step(6'b000000, 0, 1);
  endtask

  task automatic test_hold();
    int bad = 0;
    do_reset();
    m_cur = 0;
    step(6'b010000, 0, 0);
    step(6'b000000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step((i == 3) ? 6'b000001 : 6'b000000, 0, 0);
      checks++;
      if ({tgt_if.tgt_valid, tgt_if.tgt_floor} !== {1'b1, 3'd4}) begin
        failures++;
        bad++;
        if (bad < 4) $display("FAIL hold_stable cyc=%0d got=%h exp=%h", i, {tgt_if.tgt_valid, tgt_if.tgt_floor}, {1'b1, 3'd4});
      end
    end
    step(6'b000000, 1, 0);
    checks++;
    if (tgt_if.tgt_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_drop got=%b exp=0", tgt_if.tgt_valid);
    end
    m_cur = 4;
    step(6'b000000, 0, 1);
    checks++;
    if (pending !== 6'b000001) begin
      failures++;
      $display("FAIL hold_arrive got=%b exp=000001", pending);
    end
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL hold_next got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up}, {1'b1, 3'd0, 1'b0});
    end
  endtask

  task automatic test_arrive_clear();
    do_reset();
    m_cur = 0;
    step(6'b000100, 0, 0);
    step(6'b000000, 0, 0);
    step(6'b000000, 1, 0);
    m_cur = 2;
    step(6'b100100, 0, 1);
    checks++;
    if (pending !== 6'b100000) begin
      failures++;
      $display("FAIL clear_wins got=%b exp=100000", pending);
    end
  endtask

  task automatic test_arrive_ignored();
    do_reset();
    m_cur = 0;
    step(6'b000000, 0, 1);
    checks++;
    if ({pending, busy} !== {6'b0, 1'b0}) begin
      failures++;
      $display("FAIL ign_idle got=%h exp=%h", {pending, busy}, {6'b0, 1'b0});
    end
    step(6'b000010, 0, 0);
    step(6'b000000, 0, 0);
    step(6'b000000, 0, 1);
    checks++;
    if ({pending, tgt_if.tgt_valid, tgt_if.tgt_floor} !== {6'b000010, 1'b1, 3'd1}) begin
      failures++;
      $display("FAIL ign_issue got=%h exp=%h", {pending, tgt_if.tgt_valid, tgt_if.tgt_floor}, {6'b000010, 1'b1, 3'd1});
    end
    step(6'b000000, 1, 1);
    checks++;
    if ({pending, tgt_if.tgt_valid, busy} !== {6'b000010, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ign_ready_arrive got=%h exp=%h", {pending, tgt_if.tgt_valid, busy}, {6'b000010, 1'b0, 1'b1});
    end
    m_cur = 1;
    step(6'b000000, 0, 1);
    checks++;
    if ({pending, busy} !== {6'b0, 1'b0}) begin
      failures++;
      $display("FAIL ign_real_arrive got=%h exp=%h", {pending, busy}, {6'b0, 1'b0});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    m_cur = 7;
    step(6'b100001, 0, 0);
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {1'b1, 3'd5, 1'b1}) begin
      failures++;
      $display("FAIL sat_top got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up}, {1'b1, 3'd5, 1'b1});
    end
    step(6'b000000, 1, 0);
    m_cur = 6;
    step(6'b000000, 0, 1);
    step(6'b000000, 0, 0);
    checks++;
    if ({pending, tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up} !== {6'b000001, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL sat_flip got=%h exp=%h", {pending, tgt_if.tgt_valid, tgt_if.tgt_floor, sweep_up},
               {6'b000001, 1'b1, 3'd0, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [N-1:0] call;
    logic ready, arr;
    int bad = 0;
    do_reset();
    m_cur = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      call  = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      ready = 1'($urandom_range(0, 1));
      arr   = 1'b0;
      if (m_phase == 2 && $urandom_range(0, 2) == 0) begin
        m_cur = m_tgt;
        arr   = 1'b1;
      end else if (m_phase != 2 && $urandom_range(0, 11) == 0) begin
        arr = 1'b1;
      end
      if (m_phase == 0 && $urandom_range(0, 7) == 0) m_cur = int'($urandom_range(0, 7));
      step(call, ready, arr);
      checks++;
      if ({pending, tgt_if.tgt_valid, busy, sweep_up} !== {m_pend, m_phase == 1, m_phase != 0, m_sweep}) begin
        failures++;
        bad++;
        if (bad < 6) $display("FAIL rand_state cyc=%0d got=%h exp=%h", cyc, {pending, tgt_if.tgt_valid, busy, sweep_up},
                              {m_pend, m_phase == 1, m_phase != 0, m_sweep});
      end
      if (m_phase == 1) begin
        checks++;
        if (tgt_if.tgt_floor !== 3'(m_tgt)) begin
          failures++;
          bad++;
          if (bad < 6) $display("FAIL rand_target cyc=%0d got=%0d exp=%0d", cyc, tgt_if.tgt_floor, m_tgt);
        end
      end
    end
  endtask

`ifdef ELEV_HOME_EN
  task automatic test_home();
    do_reset();
    m_cur = 3;
    repeat (7) step(6'b000000, 0, 0);
    checks++;
    if (tgt_if.tgt_valid !== 1'b0) begin
      failures++;
      $display("FAIL home_early got=%b exp=0", tgt_if.tgt_valid);
    end
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL home_offer got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor}, {1'b1, 3'd0});
    end
    do_reset();
    m_cur = 3;
    repeat (4) step(6'b000000, 0, 0);
    step(6'b001000, 0, 0);
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor} !== {1'b1, 3'd3}) begin
      failures++;
      $display("FAIL home_call got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor}, {1'b1, 3'd3});
    end
    step(6'b000000, 1, 0);
    step(6'b000000, 0, 1);
    repeat (7) step(6'b000000, 0, 0);
    checks++;
    if (tgt_if.tgt_valid !== 1'b0) begin
      failures++;
      $display("FAIL home_restart_early got=%b exp=0", tgt_if.tgt_valid);
    end
    step(6'b000000, 0, 0);
    checks++;
    if ({tgt_if.tgt_valid, tgt_if.tgt_floor} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL home_restart_offer got=%h exp=%h", {tgt_if.tgt_valid, tgt_if.tgt_floor}, {1'b1, 3'd0});
    end
    step(6'b000000, 1, 0);
    step(6'b000001, 0, 0);
    m_cur = 0;
    step(6'b000000, 0, 1);
    checks++;
    if ({pending, busy} !== {6'b000001, 1'b0}) begin
      failures++;
      $display("FAIL home_no_clear got=%h exp=%h", {pending, busy}, {6'b000001, 1'b0});
    end
  endtask
`endif

  initial begin
    tgt_if.tgt_ready = 1'b0;
    tgt_if.arrive    = 1'b0;
    m_cur            = 0;
    model_reset();
    test_reset();
    test_look_up();
    test_look_flip();
    test_hold();
    test_arrive_clear();
    test_arrive_ignored();
    test_saturate();
`ifdef ELEV_HOME_EN
    test_home();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
